// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind a UART receiver: assembles [SYNC][LEN][payload][CHK] frames,
// holds one validated packet for a consumer and reports overrun/len/checksum/timeout errors.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         ADDR_W       = 4,
    parameter int         TIMEOUT_CLKS = 1740
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Pkt_Valid,
    output logic [7:0]        o_Pkt_Len,
    input  logic              i_Pkt_Ack,
    output logic              o_Err,
    output logic [1:0]        o_Err_Code,
    output logic              o_Busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                GAP_W     = $clog2(TIMEOUT_CLKS);
    localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_BADLEN  = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         chk_q, chk_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         pkt_len_q, pkt_len_d;
    logic               pkt_valid_q;
    logic               busy_q;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [7:0]         buf_q [DEPTH];
    logic               wr_en_s;
    logic               in_frame_s;
    logic               timeout_s;
    logic               is_sync_s;

    assign in_frame_s = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign timeout_s  = in_frame_s && !i_Rx_DV && (gap_q == GAP_LIMIT);
    assign is_sync_s  = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);

    // Next-state, datapath and error decode
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        chk_d      = chk_q;
        idx_d      = idx_q;
        pkt_len_d  = pkt_len_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        wr_en_s    = 1'b0;

        if (in_frame_s && !i_Rx_DV && !timeout_s) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = GAP_W'(0);
        end

        case (state_q)
            S_IDLE: begin
                if (is_sync_s) begin
                    state_d = S_LEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BADLEN;
                        state_d    = S_IDLE;
                    end else begin
                        len_d   = i_Rx_Byte;
                        chk_d   = i_Rx_Byte;
                        idx_d   = {ADDR_W{1'b0}};
                        state_d = S_PAYLOAD;
                    end
                end else if (timeout_s) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    wr_en_s = 1'b1;
                    chk_d   = chk_update(chk_q, i_Rx_Byte);
                    idx_d   = idx_q + ADDR_W'(1);
                    if (8'(idx_q) == (len_q - 8'd1)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else if (timeout_s) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_CHECK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == chk_q) begin
                        pkt_len_d = len_q;
                        state_d   = S_HOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHKSUM;
                        state_d    = S_IDLE;
                    end
                end else if (timeout_s) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_HOLD: begin
                // Ack releases the packet; a simultaneous byte is judged as if already idle
                if (i_Pkt_Ack) begin
                    if (is_sync_s) begin
                        state_d = S_LEN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (i_Rx_DV) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                    state_d    = S_HOLD;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= 8'd0;
            chk_q       <= 8'd0;
            idx_q       <= {ADDR_W{1'b0}};
            gap_q       <= GAP_W'(0);
            pkt_len_q   <= 8'd0;
            pkt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            pkt_len_q   <= pkt_len_d;
            pkt_valid_q <= (state_d == S_HOLD);
            busy_q      <= (state_d != S_IDLE);
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload buffer; only written in PAYLOAD, so it stays frozen while a packet is held
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 8'd0;
            end
        end else if (wr_en_s) begin
            buf_q[idx_q] <= i_Rx_Byte;
        end else begin
            buf_q <= buf_q;
        end
    end

    assign o_Rd_Data   = buf_q[i_Rd_Addr];
    assign o_Pkt_Valid = pkt_valid_q;
    assign o_Pkt_Len   = pkt_len_q;
    assign o_Err       = err_q;
    assign o_Err_Code  = err_code_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Bench for uart_rx_packet_ctrl: frame-level reference model fed by directed and random
// byte streams, compared against the DUT every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx_packet_ctrl;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         MAX_LEN = 16;
    localparam int         ADDR_W  = 4;
    localparam int         TIMEOUT = 1740;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              dv      = 1'b0;
    logic [7:0]        rx_byte = 8'd0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              ack     = 1'b0;
    logic [7:0]        rd_data;
    logic              pkt_valid;
    logic [7:0]        pkt_len;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    always #5 clk = ~clk;

    uart_rx_packet_ctrl #(
        .SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT_CLKS(TIMEOUT)
    ) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(rx_byte),
        .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data), .o_Pkt_Valid(pkt_valid),
        .o_Pkt_Len(pkt_len), .i_Pkt_Ack(ack), .o_Err(err), .o_Err_Code(err_code),
        .o_Busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes of the frame in progress, plus the held-packet view
    logic [7:0] frm [$];
    logic [7:0] mbuf [16];
    bit         held;
    logic [7:0] m_len;
    bit         m_err;
    logic [1:0] m_code;
    int         cyc;
    int         last_dv;
    bit         cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        frm.delete();
        for (int i = 0; i < 16; i++) mbuf[i] = 8'd0;
        held   = 1'b0;
        m_len  = 8'd0;
        m_err  = 1'b0;
        m_code = 2'b00;
    endtask

    task automatic raise(input logic [1:0] code);
        m_err  = 1'b1;
        m_code = code;
        frm.delete();
    endtask

    task automatic model_step();
        int         n;
        int         len;
        logic [7:0] x;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        if (held) begin
            if (ack) begin
                held = 1'b0;
                if (dv && rx_byte == SYNC) begin
                    frm.push_back(rx_byte);
                    last_dv = cyc;
                end
            end else if (dv) begin
                m_err  = 1'b1;
                m_code = 2'b00;
            end
        end else if (frm.size() == 0) begin
            if (dv && rx_byte == SYNC) begin
                frm.push_back(rx_byte);
                last_dv = cyc;
            end
        end else if (dv) begin
            last_dv = cyc;
            frm.push_back(rx_byte);
            n = frm.size();
            len = int'(frm[1]);
            if (n == 2) begin
                if (len == 0 || len > MAX_LEN) raise(2'b01);
            end else if (n <= len + 2) begin
                mbuf[n-3] = rx_byte;
            end else begin
                x = 8'd0;
                for (int i = 1; i < n; i++) x ^= frm[i];
                if (x == 8'd0) begin
                    held  = 1'b1;
                    m_len = frm[1];
                    frm.delete();
                end else begin
                    raise(2'b10);
                end
            end
        end else if (cyc - last_dv == TIMEOUT) begin
            raise(2'b11);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("pkt_valid", 32'(pkt_valid), 32'(held));
            check("pkt_len", 32'(pkt_len), 32'(m_len));
            check("err", 32'(err), 32'(m_err));
            check("err_code", 32'(err_code), 32'(m_code));
            check("busy", 32'(busy), 32'(held || frm.size() != 0));
            check("rd_data", 32'(rd_data), 32'(mbuf[rd_addr]));
        end
    end

    task automatic tick(input bit d, input logic [7:0] b, input bit a);
        dv      = d;
        rx_byte = b;
        ack     = a;
        rd_addr = ADDR_W'($urandom_range(0, 15));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic read_chk(input string name, input int addr, input logic [7:0] exp);
        rd_addr = ADDR_W'(addr);
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic send_rand(input logic [7:0] q[$]);
        foreach (q[i]) begin
            repeat ($urandom_range(0, 3)) tick(1'b0, 8'($urandom), $urandom_range(0, 3) == 0);
            tick(1'b1, q[i], $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic rand_frame();
        logic [7:0] q[$];
        logic [7:0] c;
        int kind = $urandom_range(0, 9);
        int len  = $urandom_range(1, MAX_LEN);
        if (kind == 8) begin
            repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
        end else if (kind == 7) begin
            q.push_back(SYNC);
            q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255)));
        end else begin
            q.push_back(SYNC);
            q.push_back(8'(len));
            c = 8'(len);
            for (int i = 0; i < len; i++) begin
                q.push_back(8'($urandom));
                c ^= q[q.size()-1];
            end
            if (kind == 6) c ^= 8'($urandom_range(1, 255));
            q.push_back(c);
        end
        send_rand(q);
        repeat ($urandom_range(0, 4)) tick(1'b0, 8'($urandom), $urandom_range(0, 1) == 0);
    endtask

    initial begin
        model_reset();
        cyc     = 0;
        last_dv = 0;
        @(posedge clk);
        #1;
        idle(3);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        idle(2);
        cmp_en = 1'b1;

        // Good frame of three bytes
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        check("t1_busy_pre", 32'(busy), 32'd1);
        send(8'h03);
        check("t1_valid", 32'(pkt_valid), 32'd1);
        check("t1_len", 32'(pkt_len), 32'd3);
        read_chk("t1_rd0", 0, 8'h11);
        read_chk("t1_rd1", 1, 8'h22);
        read_chk("t1_rd2", 2, 8'h33);
        tick(1'b0, 8'h00, 1'b1);
        check("t1_ack", 32'(pkt_valid), 32'd0);

        // Bad checksum
        send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
        check("t2_err", 32'(err), 32'd1);
        check("t2_code", 32'(err_code), 32'd2);
        check("t2_valid", 32'(pkt_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);

        // Illegal LEN values, then a good frame
        send(8'hA5); send(8'h00);
        check("t3_err0", 32'(err), 32'd1);
        check("t3_code0", 32'(err_code), 32'd1);
        idle(1);
        check("t3_pulse", 32'(err), 32'd0);
        check("t3_hold_code", 32'(err_code), 32'd1);
        send(8'hA5); send(8'h11);
        check("t3_err17", 32'(err), 32'd1);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h7E);
        check("t3_valid", 32'(pkt_valid), 32'd1);
        check("t3_len", 32'(pkt_len), 32'd1);
        tick(1'b0, 8'h00, 1'b1);

        // Timeout exactly at the gap limit
        send(8'hA5); send(8'h04); send(8'h01);
        idle(TIMEOUT - 1);
        check("t4_no_err", 32'(err), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        idle(1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_code", 32'(err_code), 32'd3);
        check("t4_idle", 32'(busy), 32'd0);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
        check("t4_valid", 32'(pkt_valid), 32'd1);

        // Overrun while held, then Ack together with SYNC
        send(8'h7E);
        check("t5_err", 32'(err), 32'd1);
        check("t5_code", 32'(err_code), 32'd0);
        check("t5_valid", 32'(pkt_valid), 32'd1);
        read_chk("t5_rd0", 0, 8'h10);
        read_chk("t5_rd1", 1, 8'h20);
        tick(1'b1, 8'hA5, 1'b1);
        check("t5_ack_err", 32'(err), 32'd0);
        check("t5_ack_valid", 32'(pkt_valid), 32'd0);
        check("t5_ack_busy", 32'(busy), 32'd1);
        send(8'h01); send(8'hC3); send(8'hC2);
        check("t5_valid2", 32'(pkt_valid), 32'd1);
        read_chk("t5_rd2", 0, 8'hC3);
        tick(1'b0, 8'h00, 1'b1);

        // Async reset in PAYLOAD
        send(8'hA5); send(8'h00);
        send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
        rst_n = 1'b0;
        model_reset();
        rd_addr = '0;
        #1;
        check("t6_valid", 32'(pkt_valid), 32'd0);
        check("t6_len", 32'(pkt_len), 32'd0);
        check("t6_code", 32'(err_code), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rd", 32'(rd_data), 32'd0);
        idle(2);
        rst_n = 1'b1;
        send(8'h00); send(8'hFF);
        check("t6_stray_busy", 32'(busy), 32'd0);
        check("t6_stray_err", 32'(err), 32'd0);

        // Random traffic, including gaps straddling the timeout limit
        for (int k = 0; k < 4; k++) begin
            send(8'hA5); send(8'h03); send(8'h44);
            idle(TIMEOUT - 2 + k);
            send(8'h55); send(8'h66); send(8'h03 ^ 8'h44 ^ 8'h55 ^ 8'h66);
            idle(3);
            tick(1'b0, 8'h00, 1'b1);
        end
        for (int k = 0; k < 400; k++) rand_frame();
        idle(4);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
